// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbitrated N:1 multiplexer with a registered
//               valid/ready output slice.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_src,
    input  logic             out_ready
);

    localparam logic [SW-1:0] c_last = SW'(N - 1);
    localparam logic [SW:0]   c_n    = (SW + 1)'(N);

    logic [SW-1:0] r_ptr;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_src;

    logic          w_load;
    logic          w_found;
    logic [SW-1:0] w_gidx;
    logic [N-1:0]  w_grant;
    logic [W-1:0]  w_sel_data;

    assign w_load = !r_out_valid || out_ready;

    // Walk requesters from the pointer onward; the wrap is an explicit
    // subtract so non-power-of-two N never aliases onto a missing requester.
    always_comb begin
        logic [SW:0]   v_sum;
        logic [SW-1:0] v_idx;
        w_found = 1'b0;
        w_gidx  = '0;
        v_sum   = '0;
        v_idx   = '0;
        for (int k = 0; k < N; k++) begin
            v_sum = {1'b0, r_ptr} + (SW + 1)'(k);
            if (v_sum >= c_n) begin
                v_sum = v_sum - c_n;
            end
            v_idx = v_sum[SW-1:0];
            if (!w_found && in_valid[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = v_idx;
            end
        end
    end

    assign w_grant    = w_found ? (N'(1) << w_gidx) : '0;
    assign w_sel_data = in_data[w_gidx*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= w_gidx;
                r_ptr       <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_load ? w_grant : '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed self-checking bench for rr_mux_arbiter (N=4, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    int pass_cnt;
    int total_cnt;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_src_seq [4];

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;

        // Reset holds everything at zero even with requests present
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_ptr",       32'(dut.r_ptr), 32'd0);

        // Release with no requests: stays idle
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready2", 32'(in_ready),  32'd0);

        // Fairness: all requesting, sources 0,1,2,3,0,1
        in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            step();
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_src",   32'(out_src),   32'(k % 4));
            check("fair_data",  32'(out_data),  32'(8'hA0 + (k % 4)));
        end

        // Asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_ptr",       32'(dut.r_ptr), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("arst_first_src",  32'(out_src),  32'd0);
        check("arst_first_data", 32'(out_data), 32'hA0);
        // Continue rotation 1,2,3 so pointer returns to 0
        for (int k = 1; k < 4; k++) begin
            step();
            check("arst_rot_src", 32'(out_src), 32'(k));
        end
        check("arst_ptr_wrap", 32'(dut.r_ptr), 32'd0);

        // Skip and wrap: requesters 0 and 3 only
        in_valid = 4'b1001;
        exp_src_seq[0] = 4'd0;
        exp_src_seq[1] = 4'd3;
        exp_src_seq[2] = 4'd0;
        exp_src_seq[3] = 4'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("skip_in_ready", 32'(in_ready), (k % 2 == 0) ? 32'h1 : 32'h8);
            step();
            check("skip_src",  32'(out_src),  32'(exp_src_seq[k]));
            check("skip_data", 32'(out_data), (k % 2 == 0) ? 32'hA0 : 32'hA3);
        end

        // Backpressure: hold A1 while downstream stalls
        in_valid = 4'b0010;
        step();
        check("bp_load_data", 32'(out_data), 32'hA1);
        check("bp_ptr0",      32'(dut.r_ptr), 32'd2);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'hA1);
            check("bp_src",   32'(out_src),   32'd1);
            check("bp_ptr",   32'(dut.r_ptr), 32'd2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", 32'(in_ready), 32'h4);
        step();
        check("bp_resume_src",  32'(out_src),  32'd2);
        check("bp_resume_data", 32'(out_data), 32'hA2);

        // Drain to empty, then a single word from requester 2
        in_valid = 4'b0000;
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        in_valid = 4'b0100;
        step();
        check("drain_pulse_valid", 32'(out_valid), 32'd1);
        check("drain_pulse_src",   32'(out_src),   32'd2);
        in_valid = 4'b0000;
        step();
        check("drain_after_valid", 32'(out_valid), 32'd0);
        check("drain_hold_src",    32'(out_src),   32'd2);
        step();
        check("drain_idle_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
